// File: rtl/bus_read_ctrl_pkg.sv
// Shared code space for the bus read controller and the write-enable decoder.
//   SEL_*      : 3-bit read/write select codes (SEL_MEM reads memory at AR).
//   rd_state_e : read controller state encoding (StIdle, StMemWait).
package bus_read_ctrl_pkg;

  localparam logic [2:0] SEL_AC  = 3'b000;
  localparam logic [2:0] SEL_AR  = 3'b001;
  localparam logic [2:0] SEL_PC  = 3'b010;
  localparam logic [2:0] SEL_DR  = 3'b011;
  localparam logic [2:0] SEL_TR  = 3'b100;
  localparam logic [2:0] SEL_R   = 3'b101;
  localparam logic [2:0] SEL_IR  = 3'b110;
  localparam logic [2:0] SEL_MEM = 3'b111;

  typedef enum logic [0:0] {
    StIdle    = 1'b0,
    StMemWait = 1'b1
  } rd_state_e;

endpackage

// File: rtl/bus_src_mux.sv
// Combinational register source select for the common bus.
//   sel      : select code (SEL_AC..SEL_IR; SEL_MEM and anything else give 0)
//   ac_in, dr_in, tr_in, r_in, ir_in : DATA_W register values
//   ar_in, pc_in : ADDR_W address registers, zero-extended to DATA_W
//   data_out : selected value
module bus_src_mux
  import bus_read_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 12
) (
  input  logic [2:0]        sel,
  input  logic [DATA_W-1:0] ac_in,
  input  logic [ADDR_W-1:0] ar_in,
  input  logic [ADDR_W-1:0] pc_in,
  input  logic [DATA_W-1:0] dr_in,
  input  logic [DATA_W-1:0] tr_in,
  input  logic [DATA_W-1:0] r_in,
  input  logic [DATA_W-1:0] ir_in,
  output logic [DATA_W-1:0] data_out
);

  always_comb begin
    data_out = '0;
    case (sel)
      SEL_AC:  data_out = ac_in;
      SEL_AR:  data_out = DATA_W'(ar_in);
      SEL_PC:  data_out = DATA_W'(pc_in);
      SEL_DR:  data_out = dr_in;
      SEL_TR:  data_out = tr_in;
      SEL_R:   data_out = r_in;
      SEL_IR:  data_out = ir_in;
      default: data_out = '0;
    endcase
  end

endmodule

// File: rtl/bus_read_ctrl.sv
// Drives the processor common bus from one source chosen by a 3-bit read code.
// Register sources complete in one cycle; code SEL_MEM runs a memory read at AR
// with a ready handshake and a timeout.
//   clk, rst_n          : clock (rising edge), asynchronous active-low reset
//   rd_req, rd_sel      : read request and source code, accepted when busy=0
//   ac_in..ir_in        : register values (ar_in, pc_in are ADDR_W wide)
//   mem_rd, mem_addr    : memory read strobe and address (held while waiting)
//   mem_data, mem_ready : memory read data and completion
//   bus_out, bus_valid  : registered bus value and its one-cycle update pulse
//   busy                : memory read in progress, requests ignored
//   rd_err              : one-cycle pulse, memory read timed out
module bus_read_ctrl
  import bus_read_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned ADDR_W      = 12,
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rd_req,
  input  logic [2:0]        rd_sel,
  input  logic [DATA_W-1:0] ac_in,
  input  logic [DATA_W-1:0] dr_in,
  input  logic [DATA_W-1:0] tr_in,
  input  logic [DATA_W-1:0] r_in,
  input  logic [DATA_W-1:0] ir_in,
  input  logic [ADDR_W-1:0] ar_in,
  input  logic [ADDR_W-1:0] pc_in,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_data,
  input  logic              mem_ready,
  output logic [DATA_W-1:0] bus_out,
  output logic              bus_valid,
  output logic              busy,
  output logic              rd_err
);

  // One spare bit so the counter can never wrap before the timeout compare.
  localparam int unsigned    CNT_W    = $clog2(MEM_TIMEOUT) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

  rd_state_e         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] bus_out_q, bus_out_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              bus_valid_q, bus_valid_d;
  logic              rd_err_q, rd_err_d;
  logic [DATA_W-1:0] src_data;

  bus_src_mux #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_src_mux (
    .sel      (rd_sel),
    .ac_in    (ac_in),
    .ar_in    (ar_in),
    .pc_in    (pc_in),
    .dr_in    (dr_in),
    .tr_in    (tr_in),
    .r_in     (r_in),
    .ir_in    (ir_in),
    .data_out (src_data)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bus_out_d   = bus_out_q;
    mem_addr_d  = mem_addr_q;
    bus_valid_d = 1'b0;
    rd_err_d    = 1'b0;
    case (state_q)
      StIdle: begin
        if (rd_req) begin
          // Unknown codes fall to default: no request.
          case (rd_sel)
            SEL_MEM: begin
              mem_addr_d = ar_in;
              cnt_d      = '0;
              state_d    = StMemWait;
            end
            SEL_AC, SEL_AR, SEL_PC, SEL_DR, SEL_TR, SEL_R, SEL_IR: begin
              bus_out_d   = src_data;
              bus_valid_d = 1'b1;
            end
            default: ;
          endcase
        end
      end
      StMemWait: begin
        // Ready wins over timeout on the final cycle.
        if (mem_ready) begin
          bus_out_d   = mem_data;
          bus_valid_d = 1'b1;
          state_d     = StIdle;
        end else if (cnt_q == CNT_LAST) begin
          rd_err_d = 1'b1;
          state_d  = StIdle;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      bus_out_q   <= '0;
      mem_addr_q  <= '0;
      bus_valid_q <= 1'b0;
      rd_err_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bus_out_q   <= bus_out_d;
      mem_addr_q  <= mem_addr_d;
      bus_valid_q <= bus_valid_d;
      rd_err_q    <= rd_err_d;
    end
  end

  // Strobe and busy decode straight from the state register, so both drop
  // the moment reset asserts.
  assign mem_rd    = (state_q == StMemWait);
  assign busy      = (state_q == StMemWait);
  assign mem_addr  = mem_addr_q;
  assign bus_out   = bus_out_q;
  assign bus_valid = bus_valid_q;
  assign rd_err    = rd_err_q;

`ifndef SYNTHESIS
  sel_known_a: assert property (@(posedge clk) disable iff (!rst_n)
    (rd_req && !busy) |-> !$isunknown(rd_sel));
`endif

endmodule

// File: tb/tb_bus_read_ctrl.sv
module tb_bus_read_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rd_req;
  logic [2:0]  rd_sel;
  logic [15:0] ac_in, dr_in, tr_in, r_in, ir_in;
  logic [11:0] ar_in, pc_in;
  logic        mem_rd;
  logic [11:0] mem_addr;
  logic [15:0] mem_data;
  logic        mem_ready;
  logic [15:0] bus_out;
  logic        bus_valid;
  logic        busy;
  logic        rd_err;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  bus_read_ctrl #(
    .DATA_W      (16),
    .ADDR_W      (12),
    .MEM_TIMEOUT (15)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rd_req    (rd_req),
    .rd_sel    (rd_sel),
    .ac_in     (ac_in),
    .dr_in     (dr_in),
    .tr_in     (tr_in),
    .r_in      (r_in),
    .ir_in     (ir_in),
    .ar_in     (ar_in),
    .pc_in     (pc_in),
    .mem_rd    (mem_rd),
    .mem_addr  (mem_addr),
    .mem_data  (mem_data),
    .mem_ready (mem_ready),
    .bus_out   (bus_out),
    .bus_valid (bus_valid),
    .busy      (busy),
    .rd_err    (rd_err)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge; outputs are stable when this returns.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue a memory read at addr; raise mem_ready while the strobe is in its
  // ready_at-th cycle (0 = never). A register request is held throughout the
  // busy period to show it is ignored, and ar_in is disturbed to show the
  // address is held.
  task automatic run_mem(input int ready_at, input logic [11:0] addr,
                         output int strobe, output int valids, output int errs,
                         output logic [15:0] data, output int addr_bad);
    strobe   = 0;
    valids   = 0;
    errs     = 0;
    addr_bad = 0;
    data     = 16'h0;
    ar_in    = addr;
    rd_req   = 1'b1;
    rd_sel   = 3'b111;
    tick();
    rd_sel   = 3'b000;
    ar_in    = ~addr;
    for (int i = 0; i < 40; i++) begin
      if (mem_rd !== 1'b1) break;
      strobe++;
      if (mem_addr !== addr) addr_bad++;
      mem_ready = (strobe == ready_at);
      tick();
      if (bus_valid === 1'b1) begin
        valids++;
        data = bus_out;
      end
      if (rd_err === 1'b1) errs++;
    end
    mem_ready = 1'b0;
    rd_req    = 1'b0;
    ar_in     = addr;
  endtask

  logic [15:0] exp_reg [7];
  int          strobe, valids, errs, addr_bad, cnt;
  logic [15:0] mdata;

  initial begin
    exp_reg = '{16'h1111, 16'h0ABC, 16'h03CD, 16'h4444, 16'h5555, 16'h6666, 16'h7777};
    rst_n     = 1'b0;
    rd_req    = 1'b0;
    rd_sel    = 3'b000;
    ac_in     = 16'h1111;
    dr_in     = 16'h4444;
    tr_in     = 16'h5555;
    r_in      = 16'h6666;
    ir_in     = 16'h7777;
    ar_in     = 12'hABC;
    pc_in     = 12'h3CD;
    mem_data  = 16'hBEEF;
    mem_ready = 1'b0;

    // Reset and idle
    repeat (3) tick();
    check_eq("rst_bus_out", 32'(bus_out), 32'h0);
    check_eq("rst_mem_addr", 32'(mem_addr), 32'h0);
    check_eq("rst_outs", {28'h0, mem_rd, bus_valid, busy, rd_err}, 32'h0);
    rst_n = 1'b1;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus_valid !== 1'b0) cnt++;
    end
    check_eq("idle_no_valid", 32'(cnt), 32'h0);

    // Register sweep, back to back
    for (int i = 0; i < 7; i++) begin
      rd_req = 1'b1;
      rd_sel = 3'(i);
      tick();
      check_eq($sformatf("sweep_valid_%0d", i), 32'(bus_valid), 32'h1);
      check_eq($sformatf("sweep_data_%0d", i), 32'(bus_out), 32'(exp_reg[i]));
    end
    rd_req = 1'b0;
    tick();
    check_eq("sweep_end_valid", 32'(bus_valid), 32'h0);
    check_eq("sweep_hold", 32'(bus_out), 32'h7777);

    // Memory read, ready in the third strobe cycle
    run_mem(3, 12'h040, strobe, valids, errs, mdata, addr_bad);
    check_eq("mem3_strobe", 32'(strobe), 32'd3);
    check_eq("mem3_addr_bad", 32'(addr_bad), 32'd0);
    check_eq("mem3_valids", 32'(valids), 32'd1);
    check_eq("mem3_data", 32'(mdata), 32'hBEEF);
    check_eq("mem3_errs", 32'(errs), 32'd0);
    check_eq("mem3_busy", 32'(busy), 32'h0);
    tick();
    check_eq("mem3_not_queued", 32'(bus_valid), 32'h0);

    // Timeout
    mem_data = 16'hDEAD;
    run_mem(0, 12'h055, strobe, valids, errs, mdata, addr_bad);
    check_eq("to_strobe", 32'(strobe), 32'd15);
    check_eq("to_valids", 32'(valids), 32'd0);
    check_eq("to_errs", 32'(errs), 32'd1);
    check_eq("to_bus_hold", 32'(bus_out), 32'hBEEF);
    check_eq("to_addr_bad", 32'(addr_bad), 32'd0);
    tick();
    check_eq("to_err_pulse", 32'(rd_err), 32'h0);
    rd_req = 1'b1;
    rd_sel = 3'b011;
    tick();
    rd_req = 1'b0;
    check_eq("to_after_valid", 32'(bus_valid), 32'h1);
    check_eq("to_after_data", 32'(bus_out), 32'h4444);

    // Ready on the final timeout cycle
    mem_data = 16'hCAFE;
    run_mem(15, 12'h066, strobe, valids, errs, mdata, addr_bad);
    check_eq("last_strobe", 32'(strobe), 32'd15);
    check_eq("last_valids", 32'(valids), 32'd1);
    check_eq("last_data", 32'(mdata), 32'hCAFE);
    check_eq("last_errs", 32'(errs), 32'd0);
    tick();
    check_eq("last_err_after", 32'(rd_err), 32'h0);

    // Asynchronous reset two cycles into a memory read
    ar_in  = 12'h077;
    rd_req = 1'b1;
    rd_sel = 3'b111;
    tick();
    rd_req = 1'b0;
    tick();
    tick();
    check_eq("ar_pre_mem_rd", 32'(mem_rd), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("ar_mem_rd_drop", 32'(mem_rd), 32'h0);
    check_eq("ar_busy_drop", 32'(busy), 32'h0);
    cnt = 0;
    repeat (2) begin
      tick();
      if (bus_valid !== 1'b0 || rd_err !== 1'b0) cnt++;
    end
    rst_n     = 1'b1;
    mem_ready = 1'b1;
    repeat (4) begin
      tick();
      if (bus_valid !== 1'b0 || rd_err !== 1'b0 || busy !== 1'b0) cnt++;
    end
    mem_ready = 1'b0;
    check_eq("ar_quiet_after", 32'(cnt), 32'd0);
    check_eq("ar_bus_cleared", 32'(bus_out), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
